// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// Requester indices match the slice order of the flattened request buses.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } arb_state_t;

    localparam int DEF_NUM_REQ = 5;

    localparam int REQ_LOAD  = 0;
    localparam int REQ_REC   = 1;
    localparam int REQ_PLAY  = 2;
    localparam int REQ_MIX   = 3;
    localparam int REQ_PITCH = 4;

endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index after last_i,
// wrapping modulo N.
module rr_picker #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  pick_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] j;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        j      = '0;
        for (int k = 1; k <= N; k++) begin
            j = IW'((int'(last_i) + k) % N);
            if (!any_o && elig_i[j]) begin
                any_o     = 1'b1;
                pick_o[j] = 1'b1;
                idx_o     = j;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Per-transaction round-robin arbiter sharing one SDRAMBus port among
// several requester cores, with a watchdog that frees a stuck port.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        req_enable,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        req_finished,
    output logic [NUM_REQ-1:0]        req_error,
    output logic [DATA_W-1:0]         req_readdata,
    output logic                      sdram_read,
    output logic                      sdram_write,
    output logic [ADDR_W-1:0]         sdram_addr,
    output logic [DATA_W-1:0]         sdram_writedata,
    input  logic [DATA_W-1:0]         sdram_readdata,
    input  logic                      sdram_finished,
    output logic                      o_busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYC - 2);
    localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT_CYC);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      last_q, last_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CW-1:0]      wdog_q, wdog_d;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]      pidx;
    logic               any;
    logic               sel_rd;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               done;

    assign elig = req_enable & (req_read | req_write);

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .elig_i (elig),
        .last_i (last_q),
        .pick_o (pick),
        .idx_o  (pidx),
        .any_o  (any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read wins when a requester raises both read and write.
    assign sel_rd = |(pick & req_read);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        err_d   = '0;
        gidx_d  = gidx_q;
        last_d  = last_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = BUSY;
                    grant_d = pick;
                    gidx_d  = pidx;
                    rd_d    = sel_rd;
                    wr_d    = !sel_rd;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wdog_d  = '0;
                end
            end
            BUSY: begin
                if (sdram_finished) begin
                    state_d = RELEASE;
                    last_d  = gidx_q;
                    grant_d = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else if (wdog_q == WD_LAST) begin
                    state_d = RELEASE;
                    last_d  = gidx_q;
                    err_d   = grant_q;
                    grant_d = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else if (wdog_q != WD_MAX) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            err_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wdog_q  <= wdog_d;
        end
    end

    // Completion is passed through in the same cycle, only while owned.
    assign done            = (state_q == BUSY) && sdram_finished;
    assign req_finished    = done ? grant_q : '0;
    assign req_readdata    = done ? sdram_readdata : '0;
    assign req_grant       = grant_q;
    assign req_error       = err_q;
    assign sdram_read      = rd_q;
    assign sdram_write     = wr_q;
    assign sdram_addr      = addr_q;
    assign sdram_writedata = wdata_q;
    assign o_busy          = (state_q == BUSY);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int N  = 5;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int T  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    en, rd, wr;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wd;
    logic [N-1:0]    grant, fin_o, err_o;
    logic [DW-1:0]   rdata_o;
    logic            s_rd, s_wr, s_fin, busy;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wd, s_rdata;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .NUM_REQ     (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (T)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .req_enable      (en),
        .req_read        (rd),
        .req_write       (wr),
        .req_addr        (addr),
        .req_writedata   (wd),
        .req_grant       (grant),
        .req_finished    (fin_o),
        .req_error       (err_o),
        .req_readdata    (rdata_o),
        .sdram_read      (s_rd),
        .sdram_write     (s_wr),
        .sdram_addr      (s_addr),
        .sdram_writedata (s_wd),
        .sdram_readdata  (s_rdata),
        .sdram_finished  (s_fin),
        .o_busy          (busy)
    );

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = '0; rd = '0; wr = '0; s_fin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int idx, output int cyc);
        idx = -1;
        cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            #1;
            if (grant != '0) begin
                cyc = c;
                for (int i = 0; i < N; i++)
                    if (grant[i]) idx = i;
                break;
            end
        end
        nchk++;
        if (idx < 0) begin
            nerr++;
            $display("FAIL grant_wait: no grant within 12 cycles");
        end
    endtask

    typedef struct {
        logic [N-1:0]  i_en;
        logic [N-1:0]  i_rd;
        logic          i_fin;
        logic [DW-1:0] i_rdat;
        logic [N-1:0]  e_grant;
        logic          e_rd;
        logic [N-1:0]  e_fin;
        logic [DW-1:0] e_rdat;
        logic          e_busy;
    } vec_t;

    vec_t tbl [16];

    // Reference model: one owner at a time, an idle gap after each
    // transaction, and round-robin choice from the last finished owner.
    int            m_owner, m_last, m_age, m_err;
    bit            m_rel, m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;

    task automatic model_reset();
        m_owner = -1; m_rel = 0; m_last = N - 1; m_age = 0;
        m_err = -1; m_rd = 0; m_addr = '0; m_wd = '0;
    endtask

    task automatic model_check();
        logic [N-1:0]  eg, ef, ee;
        logic [DW-1:0] ed;
        eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
        ef = (m_owner >= 0 && s_fin) ? eg : '0;
        ed = (m_owner >= 0 && s_fin) ? s_rdata : '0;
        ee = (m_err >= 0) ? N'(1) << m_err : '0;
        chk("rnd_grant", grant, eg);
        chk("rnd_sread", s_rd, m_owner >= 0 && m_rd);
        chk("rnd_swrite", s_wr, m_owner >= 0 && !m_rd);
        chk("rnd_saddr", s_addr, m_addr);
        chk("rnd_swdata", s_wd, m_wd);
        chk("rnd_finished", fin_o, ef);
        chk("rnd_rdata", rdata_o, ed);
        chk("rnd_error", err_o, ee);
        chk("rnd_busy", busy, m_owner >= 0);
    endtask

    task automatic model_step();
        int nxt_err;
        int j;
        nxt_err = -1;
        if (rst) begin
            model_reset();
        end else begin
            if (m_owner >= 0) begin
                if (s_fin) begin
                    m_last = m_owner; m_owner = -1; m_rel = 1;
                end else if (m_age == T - 1) begin
                    nxt_err = m_owner;
                    m_last = m_owner; m_owner = -1; m_rel = 1;
                end else begin
                    m_age++;
                end
            end else if (m_rel) begin
                m_rel = 0;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    j = (m_last + k) % N;
                    if (en[j] && (rd[j] || wr[j])) begin
                        m_owner = j;
                        m_age   = 1;
                        m_rd    = rd[j];
                        m_addr  = addr[j*AW +: AW];
                        m_wd    = wd[j*DW +: DW];
                        break;
                    end
                end
            end
            m_err = nxt_err;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g, c;
        int order [6] = '{0, 1, 3, 0, 1, 3};

        rst = 1'b1; en = '0; rd = '0; wr = '0;
        addr = '0; wd = '0; s_fin = 1'b0; s_rdata = '0;
        tick();
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_sread", s_rd, 0);
        chk("rst_swrite", s_wr, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_swdata", s_wd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", err_o, 0);
        chk("rst_finished", fin_o, 0);
        chk("rst_rdata", rdata_o, 0);

        // Single read on requester 2, then enable mask hiding requester 0.
        tbl[0]  = '{5'h1F, 5'h04, 1'b0, 32'h0, 5'h00, 1'b0, 5'h00, 32'h0, 1'b0};
        tbl[1]  = '{5'h1F, 5'h04, 1'b0, 32'h0, 5'h04, 1'b1, 5'h00, 32'h0, 1'b1};
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = tbl[1];
        tbl[5]  = tbl[1];
        tbl[6]  = '{5'h1F, 5'h04, 1'b1, 32'hDEADBEEF, 5'h04, 1'b1, 5'h04, 32'hDEADBEEF, 1'b1};
        tbl[7]  = '{5'h1F, 5'h00, 1'b0, 32'h0, 5'h00, 1'b0, 5'h00, 32'h0, 1'b0};
        tbl[8]  = tbl[7];
        tbl[9]  = '{5'h1F, 5'h00, 1'b1, 32'h55, 5'h00, 1'b0, 5'h00, 32'h0, 1'b0};
        tbl[10] = '{5'h04, 5'h05, 1'b0, 32'h0, 5'h00, 1'b0, 5'h00, 32'h0, 1'b0};
        tbl[11] = '{5'h04, 5'h05, 1'b0, 32'h0, 5'h04, 1'b1, 5'h00, 32'h0, 1'b1};
        tbl[12] = '{5'h04, 5'h05, 1'b1, 32'hCAFEF00D, 5'h04, 1'b1, 5'h04, 32'hCAFEF00D, 1'b1};
        tbl[13] = '{5'h04, 5'h01, 1'b1, 32'h11111111, 5'h00, 1'b0, 5'h00, 32'h0, 1'b0};
        tbl[14] = '{5'h04, 5'h01, 1'b0, 32'h0, 5'h00, 1'b0, 5'h00, 32'h0, 1'b0};
        tbl[15] = tbl[14];

        do_reset();
        addr[REQ_PLAY*AW +: AW] = 23'h000100;
        addr[REQ_LOAD*AW +: AW] = 23'h0ABCDE;
        for (int i = 0; i < 16; i++) begin
            tick();
            en = tbl[i].i_en; rd = tbl[i].i_rd;
            s_fin = tbl[i].i_fin; s_rdata = tbl[i].i_rdat;
            #1;
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].e_grant);
            chk($sformatf("tbl%0d_sread", i), s_rd, tbl[i].e_rd);
            chk($sformatf("tbl%0d_swrite", i), s_wr, 0);
            chk($sformatf("tbl%0d_fin", i), fin_o, tbl[i].e_fin);
            chk($sformatf("tbl%0d_rdata", i), rdata_o, tbl[i].e_rdat);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_grant != '0)
                chk($sformatf("tbl%0d_saddr", i), s_addr, 23'h000100);
        end
        s_fin = 1'b0;

        // Round-robin among 0, 1 and 3, each finishing on its 2nd busy cycle.
        do_reset();
        en = '1; rd = 5'b01011;
        for (int n = 0; n < 6; n++) begin
            wait_grant(g, c);
            chk($sformatf("rr%0d_order", n), g, order[n]);
            if (n > 0) chk($sformatf("rr%0d_gap", n), c, 2);
            tick();
            s_fin = 1'b1;
            #1;
            chk($sformatf("rr%0d_fin", n), fin_o, N'(1) << order[n]);
            tick();
            s_fin = 1'b0;
            #1;
            chk($sformatf("rr%0d_release", n), s_rd, 0);
        end

        // Write on 4 with inputs changing underneath the transaction.
        rd = '0;
        wr = 5'b10000;
        addr[REQ_PITCH*AW +: AW] = 23'h7FFFFF;
        wd[REQ_PITCH*DW +: DW]   = 32'h12345678;
        wait_grant(g, c);
        chk("wr_owner", g, REQ_PITCH);
        chk("wr_swrite", s_wr, 1);
        chk("wr_sread", s_rd, 0);
        tick();
        wr = '0;
        addr[REQ_PITCH*AW +: AW] = 23'h000001;
        wd[REQ_PITCH*DW +: DW]   = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wr_hold_addr", s_addr, 23'h7FFFFF);
            chk("wr_hold_data", s_wd, 32'h12345678);
            chk("wr_hold_write", s_wr, 1);
            tick();
        end
        s_fin = 1'b1;
        #1;
        chk("wr_fin", fin_o, 5'b10000);
        tick();
        s_fin = 1'b0;
        #1;
        chk("wr_release_write", s_wr, 0);
        chk("wr_release_grant", grant, 0);

        // Watchdog abort on 1 with 3 pending; late completion ignored.
        do_reset();
        en = '1; rd = 5'b01010;
        wait_grant(g, c);
        chk("to_owner", g, REQ_REC);
        c = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            #1;
            if (err_o != '0) begin
                c = i;
                break;
            end
        end
        chk("to_latency", c, T - 1);
        chk("to_error", err_o, 5'b00010);
        chk("to_grant", grant, 0);
        rd = 5'b01000;
        s_fin = 1'b1;
        #1;
        chk("to_late_fin", fin_o, 0);
        chk("to_late_rdata", rdata_o, 0);
        tick();
        #1;
        chk("to_err_pulse", err_o, 0);
        chk("to_idle_fin", fin_o, 0);
        tick();
        s_fin = 1'b0;
        #1;
        chk("to_next_grant", grant, 5'b01000);

        // Reset while 3 owns the port, then 0 vs 4 contention.
        tick();
        rst = 1'b1;
        rd = 5'b10001;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_grant", grant, 0);
        chk("mrst_sread", s_rd, 0);
        chk("mrst_saddr", s_addr, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_fin", fin_o, 0);
        tick();
        #1;
        chk("mrst_first", grant, 5'b00001);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            rd  = N'($urandom) & N'($urandom);
            wr  = N'($urandom) & N'($urandom);
            for (int i = 0; i < N; i++) begin
                addr[i*AW +: AW] = AW'($urandom);
                wd[i*DW +: DW]   = $urandom;
            end
            if (((cyc / 500) % 2) == 1)
                s_fin = ($urandom_range(0, 2) == 0);
            else
                s_fin = ($urandom_range(0, 19) == 0);
            s_rdata = $urandom;
            #1;
            model_check();
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
